amp_step_ctrl: RTL and testbench

//  Sequencer for the 2-bit amplitude select code of the waveform generator.
//  - Turns a debounced push-button (manual mode) or a count of completed waveform periods (auto mode) into step requests.
//  - Applies each new code only on a phase-accumulator wrap, so the output amplitude never changes mid-period.
//  - amp_sel drives the data_in select of the amplitude scaling stage.

---
 rtl/amp_step_ctrl.sv | 144 ++++++++++++++
 tb/tb_amp_step_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/amp_step_ctrl.sv
// Amplitude-code sequencer: debounced key or counted phase wraps request a step,
// applied on the next phase wrap. Define AMP_PINGPONG_EN for an up/down code sweep.
module amp_step_ctrl #(
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned SWEEP_PERIODS = 64,
  parameter int unsigned AMP_MAX       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       mode_auto,
  input  logic       phase_wrap,
  output logic [1:0] amp_sel,
  output logic       pending,
  output logic       step_done
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned SW_W  = (SWEEP_PERIODS > 1) ? $clog2(SWEEP_PERIODS) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SW_W-1:0]  SW_LAST  = SW_W'(SWEEP_PERIODS - 1);
  localparam logic [1:0]       AMP_TOP  = 2'(AMP_MAX);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_WRAP = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             key_s1, key_s2;
  logic             key_stable, key_stable_d;
  logic [DEB_W-1:0] deb_cnt;
  logic [SW_W-1:0]  sweep_cnt;
  logic             key_req, sweep_req, apply;
  logic [1:0]       amp_nxt;

  // Key synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Debounce: a new level is accepted only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt      <= '0;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
    end else begin
      key_stable_d <= key_stable;
      if (key_s2 == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_stable <= key_s2;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign key_req = key_stable_d & ~key_stable & ~mode_auto;

  // Sweep counter is held at zero in manual mode so each auto entry counts a full period
  assign sweep_req = mode_auto & phase_wrap & (sweep_cnt == SW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (!mode_auto) begin
      sweep_cnt <= '0;
    end else if (phase_wrap) begin
      if (sweep_cnt == SW_LAST) sweep_cnt <= '0;
      else                      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Step FSM
  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_req || sweep_req) state_nxt = WAIT_WRAP;
      end
      WAIT_WRAP: begin
        if (phase_wrap) begin
          state_nxt = IDLE;
          apply     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign pending = (state == WAIT_WRAP);

`ifdef AMP_PINGPONG_EN
  logic dir_up, dir_up_nxt;

  always_comb begin
    dir_up_nxt = dir_up;
    if (dir_up) begin
      amp_nxt = (amp_sel >= AMP_TOP) ? AMP_TOP : amp_sel + 2'd1;
      if (amp_nxt == AMP_TOP) dir_up_nxt = 1'b0;
    end else begin
      if (amp_sel > AMP_TOP)      amp_nxt = AMP_TOP;
      else if (amp_sel == 2'd0)   amp_nxt = 2'd0;
      else                        amp_nxt = amp_sel - 2'd1;
      if (amp_nxt == 2'd0) dir_up_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dir_up <= 1'b1;
    else if (apply) dir_up <= dir_up_nxt;
  end
`else
  always_comb begin
    amp_nxt = (amp_sel >= AMP_TOP) ? 2'd0 : amp_sel + 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_sel   <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= apply;
      if (apply) amp_sel <= amp_nxt;
    end
  end

endmodule

// File: tb/tb_amp_step_ctrl.sv
// Self-checking bench for amp_step_ctrl: directed scenarios plus random stimulus
// against a behavioural model. Honours AMP_PINGPONG_EN for the expected code sequence.
module tb_amp_step_ctrl;

  localparam int DEB = 4;
  localparam int SP  = 3;
  localparam int AM  = 3;

  logic       clk, rst_n, key_n, mode_auto, phase_wrap;
  logic [1:0] amp_sel;
  logic       pending, step_done;

  int n_chk  = 0;
  int n_pass = 0;
  int steps  = 0;

  amp_step_ctrl #(
    .DEB_CYCLES   (DEB),
    .SWEEP_PERIODS(SP),
    .AMP_MAX      (AM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .mode_auto (mode_auto),
    .phase_wrap(phase_wrap),
    .amp_sel   (amp_sel),
    .pending   (pending),
    .step_done (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Code reached after n completed steps from reset
  function automatic int exp_code(input int n);
    int p;
`ifdef AMP_PINGPONG_EN
    p = n % (2 * AM);
    return (p <= AM) ? p : 2 * AM - p;
`else
    p = n % (AM + 1);
    return p;
`endif
  endfunction

  // Behavioural model: tracks key level acceptance, wrap counting and number of completed steps
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_stab = 1'b1, m_stab_prev = 1'b1;
  bit m_pend = 1'b0, m_done = 1'b0;
  int m_run = 0, m_sw = 0, m_upd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_stab <= 1'b1; m_stab_prev <= 1'b1;
      m_run <= 0; m_sw <= 0; m_pend <= 1'b0; m_done <= 1'b0; m_upd <= 0;
    end else begin
      m_s1        <= key_n;
      m_s2        <= m_s1;
      m_stab_prev <= m_stab;
      if (m_s2 == m_stab) m_run <= 0;
      else if (m_run == DEB - 1) begin m_stab <= m_s2; m_run <= 0; end
      else m_run <= m_run + 1;
      m_sw <= !mode_auto ? 0 : (phase_wrap ? (m_sw + 1) % SP : m_sw);
      if (m_pend) begin
        m_done <= phase_wrap;
        if (phase_wrap) begin m_pend <= 1'b0; m_upd <= m_upd + 1; end
      end else begin
        m_done <= 1'b0;
        if ((m_stab_prev && !m_stab && !mode_auto) ||
            (mode_auto && phase_wrap && m_sw == SP - 1))
          m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_amp", amp_sel, 0);
      chk("rst_pending", pending, 0);
      chk("rst_step_done", step_done, 0);
    end else begin
      chk("amp", amp_sel, exp_code(m_upd));
      chk("pending", pending, m_pend);
      chk("step_done", step_done, m_done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wrap();
    phase_wrap = 1'b1; cyc(1); phase_wrap = 1'b0;
  endtask

  task automatic press();
    key_n = 1'b0; cyc(1); key_n = 1'b1; cyc(1); key_n = 1'b0; cyc(1);
    cyc(10);
    key_n = 1'b1; cyc(10);
  endtask

  initial begin
    rst_n = 1'b0; key_n = 1'b1; mode_auto = 1'b0; phase_wrap = 1'b0;
    #2;
    repeat (8) begin phase_wrap = 1'($urandom % 2); cyc(1); end
    phase_wrap = 1'b0;
    chk("reset_amp", amp_sel, 0);
    rst_n = 1'b1; cyc(3);

    // Manual presses
    press();
    chk("press_pend", pending, 1);
    chk("press_amp_hold", amp_sel, 0);
    cyc(2); wrap(); steps++;
    chk("press_amp", amp_sel, exp_code(steps));
    chk("press_pend_clr", pending, 0);
    chk("press_done", step_done, 1);
    cyc(1);
    chk("press_done_clr", step_done, 0);
    for (int i = 0; i < 4; i++) begin
      press(); cyc(2); wrap(); steps++;
      chk("press_seq", amp_sel, exp_code(steps));
    end

    // Short glitch
    key_n = 1'b0; cyc(3); key_n = 1'b1; cyc(12);
    chk("glitch_pend", pending, 0);
    wrap(); cyc(1);
    chk("glitch_amp", amp_sel, exp_code(steps));

    // Auto sweep, wrap every 10 cycles
    mode_auto = 1'b1;
    for (int w = 1; w <= 10; w++) begin
      wrap();
      if (w == 4 || w == 7 || w == 10) steps++;
      chk("auto_amp", amp_sel, exp_code(steps));
      chk("auto_pend", pending, (w % 3 == 0) ? 1 : 0);
      cyc(9);
    end
    press();
    chk("auto_key_pend", pending, 0);
    chk("auto_key_amp", amp_sel, exp_code(steps));
    mode_auto = 1'b0; cyc(2);

    // Request coincident with a wrap, then a dropped second press
    key_n = 1'b0; cyc(6);
    phase_wrap = 1'b1; cyc(1); phase_wrap = 1'b0;
    chk("coinc_pend", pending, 1);
    chk("coinc_amp", amp_sel, exp_code(steps));
    cyc(5); key_n = 1'b1; cyc(10);
    press();
    chk("drop_pend", pending, 1);
    wrap(); steps++;
    chk("drop_amp", amp_sel, exp_code(steps));
    cyc(3);
    chk("drop_no_queue", pending, 0);

    // Mode change while pending
    press();
    chk("mode_pend", pending, 1);
    mode_auto = 1'b1; cyc(3);
    wrap(); steps++;
    chk("mode_amp", amp_sel, exp_code(steps));
    chk("mode_pend_clr", pending, 0);
    cyc(9); wrap();
    chk("mode_wrap2_pend", pending, 0);
    cyc(9); wrap();
    chk("mode_wrap3_pend", pending, 1);
    cyc(3); wrap(); steps++;
    chk("mode_sweep_amp", amp_sel, exp_code(steps));
    mode_auto = 1'b0; cyc(2);

    // Reset while pending
    press();
    chk("rstp_pend", pending, 1);
    rst_n = 1'b0; #1;
    chk("rstp_pend_clr", pending, 0);
    chk("rstp_amp", amp_sel, 0);
    chk("rstp_done", step_done, 0);
    steps = 0;
    cyc(3); rst_n = 1'b1; cyc(3);

    // Random stimulus against the model
    begin
      int run_left;
      run_left = 0;
      repeat (3000) begin
        if (run_left == 0) begin
          key_n    = 1'($urandom % 2);
          run_left = $urandom_range(1, 9);
        end
        run_left--;
        if ($urandom % 60 == 0) mode_auto = ~mode_auto;
        phase_wrap = ($urandom % 6 == 0);
        rst_n      = ($urandom % 700 != 0);
        cyc(1);
      end
    end
    rst_n = 1'b1; phase_wrap = 1'b0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
